insmem_fetch_ctrl: RTL

Controller that sequences the 32x32 instruction memory (insMem). It first collects a program image word-by-word over a valid/ready write port into a staging buffer, then commits the image to the memory with a single parallel-load cycle. On command, it fetches a run of consecutive instructions from address 0 and hands each one to a downstream consumer over a valid/ready port with backpressure.

---
 rtl/insmem_fetch_ctrl.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/insmem_fetch_ctrl.sv
// insmem_fetch_ctrl
//   Sequencer for the instruction memory. A program image is streamed in
//   word by word over a valid/ready write port into a staging buffer. The
//   whole buffer is then committed to the memory in one parallel-load cycle.
//   On command, a run of consecutive instructions is fetched from address 0.
//   Each instruction is handed to a downstream consumer over a valid/ready
//   port that supports backpressure.
//
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   load_start            pulse, starts a program-load phase (IDLE only)
//   wr_valid/wr_data      program words, accepted in index order 0..DEPTH-1
//   wr_ready              high while collecting words
//   run_start/run_len     pulse plus length (1..DEPTH) of a fetch run
//   ins_valid/ins_ready   downstream handshake
//   ins_data/ins_pc       fetched instruction and its address
//   mem_img               staged image, word i at [i*WIDTH +: WIDTH]
//   mem_l/mem_e/mem_addr  memory parallel-load strobe, enable, address
//   mem_q                 registered memory read data
//   busy                  high in every state except IDLE
//   loaded                a complete image has been committed
//   done                  one-cycle pulse at the end of a run
//   err                   one-cycle pulse for a rejected run_start
module insmem_fetch_ctrl #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_start,
  input  logic                   wr_valid,
  input  logic [WIDTH-1:0]       wr_data,
  output logic                   wr_ready,
  input  logic                   run_start,
  input  logic [AW:0]            run_len,
  output logic                   ins_valid,
  input  logic                   ins_ready,
  output logic [WIDTH-1:0]       ins_data,
  output logic [AW-1:0]          ins_pc,
  output logic [WIDTH*DEPTH-1:0] mem_img,
  output logic                   mem_l,
  output logic                   mem_e,
  output logic [AW-1:0]          mem_addr,
  input  logic [WIDTH-1:0]       mem_q,
  output logic                   busy,
  output logic                   loaded,
  output logic                   done,
  output logic                   err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMMIT,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DONE
  } state_t;

  localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH-1);

  state_t           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [AW-1:0]    pc_q, pc_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [AW:0]      len_q, len_d;
  logic [AW:0]      cnt_inc;
  logic             loaded_q, loaded_d;
  logic             err_q, err_d;
  logic             ins_valid_q, ins_valid_d;
  logic [WIDTH-1:0] ins_data_q, ins_data_d;
  logic [AW-1:0]    ins_pc_q, ins_pc_d;
  logic             img_we;

  // Next-state and decoded outputs
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    pc_d        = pc_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    loaded_d    = loaded_q;
    err_d       = 1'b0;
    ins_valid_d = ins_valid_q;
    ins_data_d  = ins_data_q;
    ins_pc_d    = ins_pc_q;
    img_we      = 1'b0;
    cnt_inc     = cnt_q + 1'b1;
    wr_ready    = 1'b0;
    mem_l       = 1'b0;
    mem_e       = 1'b0;
    mem_addr    = '0;
    done        = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A load request takes priority; a simultaneous run_start is dropped
        // silently rather than flagged.
        if (load_start) begin
          state_d  = S_LOAD;
          idx_d    = '0;
          loaded_d = 1'b0;
        end else if (run_start) begin
          if (loaded_q && (run_len != '0) && (run_len <= DEPTH_W)) begin
            state_d = S_REQ;
            pc_d    = '0;
            cnt_d   = '0;
            len_d   = run_len;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_LOAD: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          img_we = 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = S_COMMIT;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      S_COMMIT: begin
        mem_l    = 1'b1;
        mem_e    = 1'b1;
        loaded_d = 1'b1;
        state_d  = S_IDLE;
      end

      S_REQ: begin
        mem_e    = 1'b1;
        mem_addr = pc_q;
        state_d  = S_WAIT;
      end

      S_WAIT: begin
        // The memory registered the word on the REQ edge, so mem_q is valid now.
        ins_data_d  = mem_q;
        ins_pc_d    = pc_q;
        ins_valid_d = 1'b1;
        state_d     = S_HOLD;
      end

      S_HOLD: begin
        if (ins_ready) begin
          ins_valid_d = 1'b0;
          cnt_d       = cnt_inc;
          if (cnt_inc == len_q) begin
            // pc stays on the last fetched address so it never wraps.
            state_d = S_DONE;
          end else begin
            pc_d    = pc_q + 1'b1;
            state_d = S_REQ;
          end
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      pc_q        <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      loaded_q    <= 1'b0;
      err_q       <= 1'b0;
      ins_valid_q <= 1'b0;
      ins_data_q  <= '0;
      ins_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pc_q        <= pc_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      loaded_q    <= loaded_d;
      err_q       <= err_d;
      ins_valid_q <= ins_valid_d;
      ins_data_q  <= ins_data_d;
      ins_pc_q    <= ins_pc_d;
    end
  end

  // Staging buffer: one register word per memory entry, all visible at once
  // so the memory can take the whole image in a single load cycle.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_img
      logic [WIDTH-1:0] word_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          word_q <= '0;
        end else if (img_we && (idx_q == AW'(gi))) begin
          word_q <= wr_data;
        end
      end
      assign mem_img[gi*WIDTH +: WIDTH] = word_q;
    end
  endgenerate

  assign busy      = (state_q != S_IDLE);
  assign loaded    = loaded_q;
  assign err       = err_q;
  assign ins_valid = ins_valid_q;
  assign ins_data  = ins_data_q;
  assign ins_pc    = ins_pc_q;

endmodule
